// File: rtl/core_types_pkg.sv
// Shared core types: write-back bundle, register index, architectural register count.
package core_types_pkg;
  localparam int NREGS = 32;
  localparam int XLEN  = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN-1:0] Wdata;
    reg_idx_t        rd;
    logic            Wreg;
  } write_back_out_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: per-register in-flight counters, RAW stall, sticky protocol error.
// RF_BYPASS_EN: a same-cycle commit of the last pending write releases the dependent read.
module wb_scoreboard
  import core_types_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic            Clock,
  input  logic            nReset,
  input  write_back_out_t wb_in,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            issue_valid,
  input  reg_idx_t        issue_rd,
  input  logic            issue_wreg,
  output logic            stall,
  output logic            sb_err
);
  localparam logic [PEND_W-1:0] CMAX = '1;
  localparam logic [PEND_W-1:0] CONE = PEND_W'(1);

  logic [NREGS-1:0][PEND_W-1:0] cnt, cnt_nxt;
  logic err_nxt, set, clr, busy1, busy2, rd_full;

  assign clr = wb_in.Wreg & (wb_in.rd != '0);
  assign set = issue_valid & issue_wreg & (issue_rd != '0) & ~stall;

`ifdef RF_BYPASS_EN
  assign busy1 = rs1_used & (cnt[rs1] != '0) & ~(clr & (wb_in.rd == rs1) & (cnt[rs1] == CONE));
  assign busy2 = rs2_used & (cnt[rs2] != '0) & ~(clr & (wb_in.rd == rs2) & (cnt[rs2] == CONE));
`else
  assign busy1 = rs1_used & (cnt[rs1] != '0);
  assign busy2 = rs2_used & (cnt[rs2] != '0);
`endif

  assign rd_full = issue_valid & issue_wreg & (cnt[issue_rd] == CMAX);
  assign stall   = busy1 | busy2 | rd_full;

  // x0 is skipped so its counter stays 0 and it never reads busy.
  always_comb begin
    cnt_nxt = cnt;
    err_nxt = sb_err;
    for (int i = 1; i < NREGS; i++) begin
      if (set && issue_rd == reg_idx_t'(i) && !(clr && wb_in.rd == reg_idx_t'(i))) begin
        if (cnt[i] == CMAX) err_nxt = 1'b1;
        else                cnt_nxt[i] = cnt[i] + CONE;
      end else if (clr && wb_in.rd == reg_idx_t'(i) && !(set && issue_rd == reg_idx_t'(i))) begin
        if (cnt[i] == '0) err_nxt = 1'b1;
        else              cnt_nxt[i] = cnt[i] - CONE;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt    <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sb_err <= err_nxt;
    end
  end
endmodule

// File: rtl/reg_file_wb.sv
// Integer register file fed by write-back, two combinational read ports, hazard scoreboard.
// RF_BYPASS_EN: forward same-cycle write-back data onto the read ports.
module reg_file_wb
  import core_types_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic            Clock,
  input  logic            nReset,
  input  write_back_out_t wb_in,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            issue_valid,
  input  reg_idx_t        issue_rd,
  input  logic            issue_wreg,
  output logic            stall,
  output logic            sb_err
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic wr_en;

  assign wr_en = wb_in.Wreg & (wb_in.rd != '0);

  // regs[0] is never written, so x0 reads 0 without a special case.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)    regs <= '0;
    else if (wr_en) regs[wb_in.rd] <= wb_in.Wdata;
  end

`ifdef RF_BYPASS_EN
  assign rdata1 = (wr_en && wb_in.rd == rs1) ? wb_in.Wdata : regs[rs1];
  assign rdata2 = (wr_en && wb_in.rd == rs2) ? wb_in.Wdata : regs[rs2];
`else
  assign rdata1 = regs[rs1];
  assign rdata2 = regs[rs2];
`endif

  wb_scoreboard #(.PEND_W(PEND_W)) u_sb (
    .Clock       (Clock),
    .nReset      (nReset),
    .wb_in       (wb_in),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_wreg  (issue_wreg),
    .stall       (stall),
    .sb_err      (sb_err)
  );
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb; expectations follow RF_BYPASS_EN when defined.
module tb_reg_file_wb;
  import core_types_pkg::*;

  logic            Clock = 1'b0;
  logic            nReset;
  write_back_out_t wb_in;
  reg_idx_t        rs1, rs2, issue_rd;
  logic            rs1_used, rs2_used, issue_valid, issue_wreg;
  logic [31:0]     rdata1, rdata2;
  logic            stall, sb_err;
  int              tests = 0;
  int              fails = 0;

  reg_file_wb #(.PEND_W(2)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .wb_in       (wb_in),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_wreg  (issue_wreg),
    .stall       (stall),
    .sb_err      (sb_err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_wb(input logic [31:0] d, input reg_idx_t r, input logic w);
    wb_in.Wdata = d;
    wb_in.rd    = r;
    wb_in.Wreg  = w;
  endtask

  task automatic set_issue(input logic v, input reg_idx_t r);
    issue_valid = v;
    issue_wreg  = v;
    issue_rd    = r;
  endtask

  initial begin
    nReset = 1'b0;
    set_wb(32'h0, 5'd0, 1'b0);
    rs1 = 5'd5; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    set_issue(1'b0, 5'd0);
    #3;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_sb_err", {31'h0, sb_err}, 32'h0);
    #9 nReset = 1'b1;
    tick();

    // Basic write/read; rd=5 issued first so the commit is legal.
    set_issue(1'b1, 5'd5);
    tick();
    set_issue(1'b0, 5'd0);
    set_wb(32'hDEADBEEF, 5'd5, 1'b1);
    tick();
    set_wb(32'h0, 5'd0, 1'b0);
    #1 chk("wr_rd5", rdata1, 32'hDEADBEEF);
    set_wb(32'h1234, 5'd0, 1'b1);
    tick();
    set_wb(32'h0, 5'd0, 1'b0);
    rs2 = 5'd0;
    #1 chk("x0_reads0", rdata2, 32'h0);
    chk("no_err_after_wr", {31'h0, sb_err}, 32'h0);

    // RAW on rd=7
    set_issue(1'b1, 5'd7);
    #1 chk("issue7_nostall", {31'h0, stall}, 32'h0);
    tick();
    set_issue(1'b0, 5'd0);
    rs1 = 5'd7; rs1_used = 1'b1;
    #1 chk("raw7_stall", {31'h0, stall}, 32'h1);
    set_wb(32'h55, 5'd7, 1'b1);
    #1;
`ifdef RF_BYPASS_EN
    chk("byp7_stall", {31'h0, stall}, 32'h0);
    chk("byp7_data", rdata1, 32'h55);
`else
    chk("nobyp7_stall", {31'h0, stall}, 32'h1);
    chk("nobyp7_data", rdata1, 32'h0);
`endif
    tick();
    set_wb(32'h0, 5'd0, 1'b0);
    #1 chk("post7_stall", {31'h0, stall}, 32'h0);
    chk("post7_data", rdata1, 32'h55);
    rs1_used = 1'b0;

    // Saturate rd=3 (max 3 in flight)
    for (int k = 0; k < 3; k++) begin
      set_issue(1'b1, 5'd3);
      #1 chk("issue3_nostall", {31'h0, stall}, 32'h0);
      tick();
    end
    #1 chk("issue3_full_stall", {31'h0, stall}, 32'h1);
    tick();
    set_issue(1'b0, 5'd0);
    rs2 = 5'd3; rs2_used = 1'b1;
    #1 chk("rd3_busy", {31'h0, stall}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      set_wb(32'h33, 5'd3, 1'b1);
      tick();
    end
    set_wb(32'h0, 5'd0, 1'b0);
    #1 chk("rd3_busy_after2", {31'h0, stall}, 32'h1);
    set_wb(32'h33, 5'd3, 1'b1);
    tick();
    set_wb(32'h0, 5'd0, 1'b0);
    #1 chk("rd3_clear", {31'h0, stall}, 32'h0);
    chk("rd3_no_err", {31'h0, sb_err}, 32'h0);
    chk("rd3_data", rdata2, 32'h33);
    rs2_used = 1'b0;

    // Same-cycle set and clear on rd=9
    set_issue(1'b1, 5'd9);
    tick();
    set_wb(32'h99, 5'd9, 1'b1);
    #1 chk("rd9_issue_ok", {31'h0, stall}, 32'h0);
    tick();
    set_issue(1'b0, 5'd0);
    set_wb(32'h0, 5'd0, 1'b0);
    rs1 = 5'd9; rs1_used = 1'b1;
    #1 chk("rd9_still_busy", {31'h0, stall}, 32'h1);
    chk("rd9_data", rdata1, 32'h99);
    chk("rd9_no_err", {31'h0, sb_err}, 32'h0);
    set_wb(32'h9A, 5'd9, 1'b1);
    tick();
    set_wb(32'h0, 5'd0, 1'b0);
    #1 chk("rd9_clear", {31'h0, stall}, 32'h0);
    rs1_used = 1'b0;

    // Spurious commit -> sticky error; rd=20 left pending
    set_wb(32'hC, 5'd12, 1'b1);
    tick();
    set_wb(32'h0, 5'd0, 1'b0);
    #1 chk("err_set", {31'h0, sb_err}, 32'h1);
    set_issue(1'b1, 5'd20);
    tick();
    set_issue(1'b0, 5'd0);
    tick();
    chk("err_sticky", {31'h0, sb_err}, 32'h1);
    rs1 = 5'd20; rs1_used = 1'b1;
    #1 chk("rd20_busy", {31'h0, stall}, 32'h1);

    // Mid-stream reset
    #2 nReset = 1'b0;
    rs2 = 5'd5;
    #1 chk("rst2_sb_err", {31'h0, sb_err}, 32'h0);
    chk("rst2_stall", {31'h0, stall}, 32'h0);
    chk("rst2_reg5", rdata2, 32'h0);
    #3 nReset = 1'b1;
    rs1_used = 1'b0;
    tick();
    rs1 = 5'd3;
    #1 chk("rst2_reg3", rdata1, 32'h0);
    set_wb(32'h20, 5'd20, 1'b1);
    tick();
    set_wb(32'h0, 5'd0, 1'b0);
    #1 chk("rst2_late_wb_err", {31'h0, sb_err}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Integer register file that consumes the write-back stage's output (Wdata/rd/Wreg) and serves two combinational read ports to decode.
- Contains a per-register pending-write scoreboard. Decode marks a destination busy at issue; write-back clears it on commit. A stall is raised on read-after-write hazards.
- Sits between the write-back stage and decode/issue.

Parameters:
- NREGS, 32, number of architectural registers (index width 5).
- PEND_W, 2, width of each pending-write counter (max in-flight writes per register = 2^PEND_W-1).

Ports:
- Clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- wb_in  in  38  write_back_out_t {Wdata[31:0], rd[4:0], Wreg} from write-back
- rs1  in  5  read address 1
- rs2  in  5  read address 2
- rs1_used  in  1  decode consumes rs1 this cycle
- rs2_used  in  1  decode consumes rs2 this cycle
- rdata1  out  32  read data 1 (combinational)
- rdata2  out  32  read data 2 (combinational)
- issue_valid  in  1  instruction issues this cycle (only when stall=0)
- issue_rd  in  5  destination of issuing instruction
- issue_wreg  in  1  issuing instruction writes a register
- stall  out  1  hazard; decode must hold
- sb_err  out  1  sticky scoreboard protocol error

Behaviour:
- Reset (async, nReset=0): all registers 0; all pending counters 0; sb_err=0; rdata*=0; stall=0.
- Write: on posedge, if Wreg=1 and rd!=0, reg[rd] <= Wdata. Writes to x0 are discarded. x0 always reads 0 and is never marked busy.
- Read: rdataN = reg[rsN], combinational, zero-latency.
- Scoreboard set: on posedge, if issue_valid & issue_wreg & issue_rd!=0 and stall=0, cnt[issue_rd] increments.
- Scoreboard clear: on posedge, if wb Wreg=1 & rd!=0, cnt[rd] decrements.
- Set and clear to the same register in the same cycle: count unchanged.
- busyN = rsN_used & (cnt[rsN] != 0).
- rd_full = issue_valid & issue_wreg & (cnt[issue_rd] == max).
- stall = busy1 | busy2 | rd_full.
- Issue while stall=1: ignored. No count change.
- Clear with cnt==0: count stays 0; sb_err<=1.
- Increment at max: not reachable given the stall gate; if forced, count holds and sb_err<=1.
- sb_err cleared only by reset.
- Reset mid-operation: all in-flight writes are forgotten. A write-back arriving after reset with cnt=0 sets sb_err. The pipeline must be flushed together with this block.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: a same-cycle write-back to rsN (Wreg=1, rd==rsN!=0) forwards Wdata onto rdataN. busyN is suppressed when cnt[rsN]==1 and that write-back is present, so the dependent instruction issues in the commit cycle.
- Undefined: rdataN shows the pre-write value, and busyN follows the count before the clear. The dependent instruction issues one cycle after commit.

Decomposition:
- core_types_pkg holds write_back_out_t (already shared), a reg_idx_t 5-bit typedef, and NREGS.
- One sub-module: wb_scoreboard. It holds the pending counters, busy/rd_full/sb_err logic, and the set/clear arbitration.
- The register array and read muxing/bypass stay in reg_file_wb.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> rdata1=0, rdata2=0, stall=0, sb_err=0.
- Write-back Wreg=1, rd=5, Wdata=0xDEADBEEF; next cycle rs1=5 -> rdata1=0xDEADBEEF. Then write rd=0 with 0x1234 -> rs2=0 reads 0.
- Issue rd=7; next cycle rs1=7, rs1_used=1 -> stall=1. Write-back rd=7, Wdata=0x55:
  - with RF_BYPASS_EN: stall=0 and rdata1=0x55 in the commit cycle.
  - without it: stall=0 and rdata1=0x55 the following cycle.
- Issue rd=3 three times (PEND_W=2 gives cnt=3); fourth issue of rd=3 -> stall=1 and cnt stays 3. Three write-backs to rd=3 -> cnt=0, busy clear.
- Issue rd=9 and write-back rd=9 in the same cycle with cnt[9]=1 -> cnt[9] stays 1 and rs1=9 is still busy.
- Write-back rd=12 with cnt[12]=0 -> sb_err=1 and remains 1. Assert nReset mid-stream -> all counts 0, registers 0, sb_err=0.
